// File: rtl/weight_fetch_seq.sv
// Streams one layer's signed weights from a 1-cycle-latency memory to a MAC over a valid/ready link.
// Define WEIGHT_FETCH_PERF_EN to add the stall_cnt performance counter output.
module weight_fetch_seq #(
    parameter int DATA_W   = 8,
    parameter int NEURON_W = 4,
    parameter int INDEX_W  = 10
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [1:0]                 layer,
    input  logic [NEURON_W-1:0]        num_neurons_m1,
    input  logic [INDEX_W-1:0]         num_inputs_m1,
    output logic [15:0]                mem_addr,
    input  logic signed [DATA_W-1:0]   mem_rdata,
    output logic                       w_valid,
    input  logic                       w_ready,
    output logic signed [DATA_W-1:0]   w_data,
    output logic [NEURON_W-1:0]        w_neuron,
    output logic [INDEX_W-1:0]         w_index,
    output logic                       w_last_in,
    output logic                       w_last,
    output logic                       busy,
    output logic                       done
`ifdef WEIGHT_FETCH_PERF_EN
    ,
    output logic [15:0]                stall_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    typedef struct packed {
        logic [DATA_W-1:0]   data;
        logic [NEURON_W-1:0] neuron;
        logic [INDEX_W-1:0]  index;
        logic                last_in;
        logic                last;
    } beat_t;

    state_t               state;
    logic [1:0]           lyr_q;
    logic [NEURON_W-1:0]  nm1_q;
    logic [INDEX_W-1:0]   im1_q;
    logic [NEURON_W-1:0]  nxt_n;
    logic [INDEX_W-1:0]   nxt_i;
    logic                 all_issued;

    // q_*: address newly on the bus this cycle; d_*: its data now on mem_rdata, not yet captured.
    logic                 q_pend;
    logic [NEURON_W-1:0]  q_n;
    logic [INDEX_W-1:0]   q_i;
    logic                 d_pend;
    logic [NEURON_W-1:0]  d_n;
    logic [INDEX_W-1:0]   d_i;

    beat_t                fifo0;
    beat_t                fifo1;
    logic [1:0]           cnt;

    logic                 pop;
    logic                 cap;
    logic [2:0]           occ;
    logic                 can_issue;
    logic                 last_addr;
    logic [1:0]           cnt_next;
    beat_t                cap_beat;

    assign w_data    = fifo0.data;
    assign w_neuron  = fifo0.neuron;
    assign w_index   = fifo0.index;
    assign w_last_in = fifo0.last_in;
    assign w_last    = fifo0.last;

    // While mem_addr is held, mem_rdata keeps presenting the uncaptured word, so it acts as a
    // third buffer slot; that lets a 2-entry FIFO sustain one beat per cycle without overflow.
    always_comb begin
        pop       = w_valid && w_ready;
        cap       = d_pend && ((cnt != 2'd2) || pop);
        occ       = {1'b0, cnt} + {2'b00, d_pend} + {2'b00, q_pend};
        can_issue = (occ - {2'b00, pop}) <= 3'd2;
        last_addr = (nxt_n == nm1_q) && (nxt_i == im1_q);
        cnt_next  = cnt - {1'b0, pop} + {1'b0, cap};
        cap_beat.data    = mem_rdata;
        cap_beat.neuron  = d_n;
        cap_beat.index   = d_i;
        cap_beat.last_in = (d_i == im1_q);
        cap_beat.last    = (d_i == im1_q) && (d_n == nm1_q);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            lyr_q      <= '0;
            nm1_q      <= '0;
            im1_q      <= '0;
            nxt_n      <= '0;
            nxt_i      <= '0;
            all_issued <= 1'b0;
            q_pend     <= 1'b0;
            q_n        <= '0;
            q_i        <= '0;
            d_pend     <= 1'b0;
            d_n        <= '0;
            d_i        <= '0;
            fifo0      <= '0;
            fifo1      <= '0;
            cnt        <= '0;
            mem_addr   <= '0;
            w_valid    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done   <= 1'b0;
            q_pend <= 1'b0;

            if (pop) begin
                if (cnt == 2'd2) begin
                    fifo0 <= fifo1;
                    if (cap) fifo1 <= cap_beat;
                end else if (cap) begin
                    fifo0 <= cap_beat;
                end
            end else if (cap) begin
                if (cnt == 2'd0) fifo0 <= cap_beat;
                else             fifo1 <= cap_beat;
            end
            cnt     <= cnt_next;
            w_valid <= (cnt_next != 2'd0);

            if (q_pend) begin
                d_pend <= 1'b1;
                d_n    <= q_n;
                d_i    <= q_i;
            end else if (cap) begin
                d_pend <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        lyr_q      <= layer;
                        nm1_q      <= num_neurons_m1;
                        im1_q      <= num_inputs_m1;
                        all_issued <= (num_neurons_m1 == '0) && (num_inputs_m1 == '0);
                        mem_addr   <= 16'({layer, {NEURON_W{1'b0}}, {INDEX_W{1'b0}}});
                        q_pend     <= 1'b1;
                        q_n        <= '0;
                        q_i        <= '0;
                        nxt_i      <= (num_inputs_m1 == '0) ? '0 : INDEX_W'(1);
                        nxt_n      <= (num_inputs_m1 == '0) ? NEURON_W'(1) : '0;
                        busy       <= 1'b1;
                        state      <= FETCH;
                    end
                end
                FETCH: begin
                    if (all_issued) begin
                        state <= DRAIN;
                    end else if (can_issue) begin
                        mem_addr <= 16'({lyr_q, nxt_n, nxt_i});
                        q_pend   <= 1'b1;
                        q_n      <= nxt_n;
                        q_i      <= nxt_i;
                        if (nxt_i == im1_q) begin
                            nxt_i <= '0;
                            nxt_n <= nxt_n + NEURON_W'(1);
                        end else begin
                            nxt_i <= nxt_i + INDEX_W'(1);
                        end
                        if (last_addr) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && fifo0.last) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef WEIGHT_FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (!reset)
            stall_cnt <= '0;
        else if ((state == IDLE) && start)
            stall_cnt <= '0;
        else if (w_valid && !w_ready && (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_weight_fetch_seq.sv
// Directed bench for weight_fetch_seq: latency, ordering, backpressure, restart and reset cases.
module tb_weight_fetch_seq;

    logic              clk;
    logic              reset;
    logic              start;
    logic [1:0]        layer;
    logic [3:0]        num_neurons_m1;
    logic [9:0]        num_inputs_m1;
    logic [15:0]       mem_addr;
    logic signed [7:0] mem_rdata;
    logic              w_valid;
    logic              w_ready;
    logic signed [7:0] w_data;
    logic [3:0]        w_neuron;
    logic [9:0]        w_index;
    logic              w_last_in;
    logic              w_last;
    logic              busy;
    logic              done;
`ifdef WEIGHT_FETCH_PERF_EN
    logic [15:0]       stall_cnt;
`endif

    weight_fetch_seq #(.DATA_W(8), .NEURON_W(4), .INDEX_W(10)) dut (
        .clk(clk), .reset(reset), .start(start), .layer(layer),
        .num_neurons_m1(num_neurons_m1), .num_inputs_m1(num_inputs_m1),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .w_neuron(w_neuron), .w_index(w_index),
        .w_last_in(w_last_in), .w_last(w_last), .busy(busy), .done(done)
`ifdef WEIGHT_FETCH_PERF_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // wmode 1: every weight is 2; wmode 0: weight = {layer, neuron[1:0], index[3:0]}
    bit wmode;
    always @(posedge clk)
        mem_rdata <= wmode ? 8'sd2 : {mem_addr[15:14], mem_addr[11:10], mem_addr[3:0]};

    typedef struct {
        logic [7:0] data;
        logic [3:0] neuron;
        logic [9:0] index;
        logic       li;
        logic       l;
        int         cyc;
    } rec_t;

    rec_t        beat_q[$];
    logic [15:0] addr_q[$];
    int          done_cnt, done_cyc, stable_err, post_beats, post_dones;
    logic [15:0] addr_c1;
    logic        busy_c1;
    logic [42:0] rst_snap;
    int          passed = 0;
    int          total  = 0;

    task automatic run_layer(input logic [1:0] l, input logic [3:0] nn, input logic [9:0] ni,
                             input int rmode, input int budget, input int restart_at,
                             input int rst_after);
        int cyc, stall_left, rst_phase;
        bit seen_v, hold;
        logic [24:0] held;
        beat_q.delete();
        addr_q.delete();
        done_cnt = 0; done_cyc = -1; stable_err = 0; post_beats = 0; post_dones = 0;
        rst_snap = '1; stall_left = 5; seen_v = 0; hold = 0; held = '0; rst_phase = 0;
        @(negedge clk);
        layer = l; num_neurons_m1 = nn; num_inputs_m1 = ni; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (cyc <= budget) begin
            if (rst_phase == 2) begin
                reset = 1'b1;
                rst_snap = {mem_addr, w_valid, w_data, w_neuron, w_index, w_last_in, w_last, busy, done};
                rst_phase = 3;
            end
            if (rst_phase == 1) begin
                reset = 1'b0;
                rst_phase = 2;
            end
            if (restart_at == cyc) begin
                start = 1'b1; layer = 2'd3; num_neurons_m1 = 4'd0; num_inputs_m1 = 10'd0;
            end else if (restart_at + 1 == cyc) begin
                start = 1'b0; layer = l; num_neurons_m1 = nn; num_inputs_m1 = ni;
            end
            case (rmode)
                1: begin
                    if (w_valid) seen_v = 1;
                    w_ready = !(seen_v && stall_left > 0);
                    if (!w_ready) stall_left--;
                end
                2: w_ready = ((cyc % 2) == 1);
                default: w_ready = 1'b1;
            endcase
            if (reset) begin
                if (cyc == 1) begin
                    addr_c1 = mem_addr;
                    busy_c1 = busy;
                end
                if (addr_q.size() == 0 || addr_q[$] != mem_addr) addr_q.push_back(mem_addr);
                if (hold && ({w_valid, w_data, w_neuron, w_index, w_last_in, w_last} !== held))
                    stable_err++;
                hold = w_valid && !w_ready;
                held = {w_valid, w_data, w_neuron, w_index, w_last_in, w_last};
                if (w_valid && w_ready) begin
                    beat_q.push_back('{w_data, w_neuron, w_index, w_last_in, w_last, cyc});
                    if (rst_phase == 3) post_beats++;
                end
                if (done) begin
                    done_cnt++;
                    if (done_cyc < 0) done_cyc = cyc;
                    if (rst_phase == 3) post_dones++;
                end
            end
            if (rst_after > 0 && rst_phase == 0 && beat_q.size() == rst_after) rst_phase = 1;
            if (done_cnt > 0 && cyc >= done_cyc + 3) break;
            cyc++;
            @(negedge clk);
        end
        w_ready = 1'b1;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        total++; if (mem_addr !== 16'h0000) $display("FAIL reset_mem_addr got %h want 0000", mem_addr); else passed++;
        total++; if (w_valid !== 1'b0) $display("FAIL reset_w_valid got %b want 0", w_valid); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
        total++; if ({done, w_last, w_last_in, w_data, w_neuron, w_index} !== '0)
            $display("FAIL reset_payload got %h want 0", {done, w_last, w_last_in, w_data, w_neuron, w_index});
        else passed++;
        reset = 1'b1;
    endtask

    task automatic test_full_layer;
        logic [23:0] act, exp;
        logic [15:0] ea;
        wmode = 1;
        run_layer(2'd0, 4'd3, 10'd15, 0, 120, -1, 0);
        total++; if (beat_q.size() !== 64) $display("FAIL full_beats got %0d want 64", beat_q.size()); else passed++;
        total++; if (busy_c1 !== 1'b1) $display("FAIL full_busy_c1 got %b want 1", busy_c1); else passed++;
        total++; if (done_cyc !== 67) $display("FAIL full_done_cycle got %0d want 67", done_cyc); else passed++;
        total++; if (done_cnt !== 1) $display("FAIL full_done_count got %0d want 1", done_cnt); else passed++;
        total++; if (addr_q.size() !== 64) $display("FAIL full_addr_count got %0d want 64", addr_q.size()); else passed++;
        if (beat_q.size() > 0) begin
            total++; if (beat_q[0].cyc !== 3) $display("FAIL full_first_beat_cycle got %0d want 3", beat_q[0].cyc); else passed++;
        end
        for (int k = 0; k < beat_q.size(); k++) begin
            exp = {8'd2, 4'(k / 16), 10'(k % 16), (k % 16) == 15, k == 63};
            act = {beat_q[k].data, beat_q[k].neuron, beat_q[k].index, beat_q[k].li, beat_q[k].l};
            total++; if (act !== exp) $display("FAIL full_beat%0d got %h want %h", k, act, exp); else passed++;
        end
        for (int k = 0; k < addr_q.size(); k++) begin
            ea = {2'b00, 4'(k / 16), 10'(k % 16)};
            total++; if (addr_q[k] !== ea) $display("FAIL full_addr%0d got %h want %h", k, addr_q[k], ea); else passed++;
        end
    endtask

    task automatic test_stall;
        logic [23:0] act, exp;
        wmode = 0;
        run_layer(2'd2, 4'd0, 10'd3, 1, 60, -1, 0);
        total++; if (beat_q.size() !== 4) $display("FAIL stall_beats got %0d want 4", beat_q.size()); else passed++;
        total++; if (addr_c1 !== 16'h8000) $display("FAIL stall_addr_c1 got %h want 8000", addr_c1); else passed++;
        total++; if (stable_err !== 0) $display("FAIL stall_payload_stable got %0d want 0", stable_err); else passed++;
        total++; if (done_cyc !== 12) $display("FAIL stall_done_cycle got %0d want 12", done_cyc); else passed++;
        total++; if (addr_q.size() !== 4) $display("FAIL stall_addr_count got %0d want 4", addr_q.size()); else passed++;
        for (int k = 0; k < addr_q.size(); k++) begin
            total++; if (addr_q[k] !== 16'h8000 + 16'(k)) $display("FAIL stall_addr%0d got %h want %h", k, addr_q[k], 16'h8000 + 16'(k)); else passed++;
        end
        for (int k = 0; k < beat_q.size(); k++) begin
            exp = {8'h80 | 8'(k), 4'd0, 10'(k), k == 3, k == 3};
            act = {beat_q[k].data, beat_q[k].neuron, beat_q[k].index, beat_q[k].li, beat_q[k].l};
            total++; if (act !== exp) $display("FAIL stall_beat%0d got %h want %h", k, act, exp); else passed++;
        end
`ifdef WEIGHT_FETCH_PERF_EN
        total++; if (stall_cnt !== 16'd5) $display("FAIL stall_cnt got %0d want 5", stall_cnt); else passed++;
`endif
    endtask

    task automatic test_toggle;
        logic [23:0] act, exp;
        wmode = 0;
        run_layer(2'd1, 4'd3, 10'd3, 2, 120, -1, 0);
        total++; if (beat_q.size() !== 16) $display("FAIL toggle_beats got %0d want 16", beat_q.size()); else passed++;
        total++; if (done_cnt !== 1) $display("FAIL toggle_done_count got %0d want 1", done_cnt); else passed++;
        total++; if (stable_err !== 0) $display("FAIL toggle_payload_stable got %0d want 0", stable_err); else passed++;
        for (int k = 0; k < beat_q.size(); k++) begin
            exp = {2'b01, 2'(k / 4), 4'(k % 4), 4'(k / 4), 10'(k % 4), (k % 4) == 3, k == 15};
            act = {beat_q[k].data, beat_q[k].neuron, beat_q[k].index, beat_q[k].li, beat_q[k].l};
            total++; if (act !== exp) $display("FAIL toggle_beat%0d got %h want %h", k, act, exp); else passed++;
        end
    endtask

    task automatic test_restart_ignored;
        logic [23:0] act, exp;
        logic [15:0] ea;
        wmode = 0;
        run_layer(2'd1, 4'd1, 10'd7, 0, 80, 4, 0);
        total++; if (beat_q.size() !== 16) $display("FAIL restart_beats got %0d want 16", beat_q.size()); else passed++;
        total++; if (done_cnt !== 1) $display("FAIL restart_done_count got %0d want 1", done_cnt); else passed++;
        total++; if (done_cyc !== 19) $display("FAIL restart_done_cycle got %0d want 19", done_cyc); else passed++;
        total++; if (addr_q.size() !== 16) $display("FAIL restart_addr_count got %0d want 16", addr_q.size()); else passed++;
        for (int k = 0; k < addr_q.size(); k++) begin
            ea = {2'b01, 4'(k / 8), 10'(k % 8)};
            total++; if (addr_q[k] !== ea) $display("FAIL restart_addr%0d got %h want %h", k, addr_q[k], ea); else passed++;
        end
        for (int k = 0; k < beat_q.size(); k++) begin
            exp = {2'b01, 2'(k / 8), 4'(k % 8), 4'(k / 8), 10'(k % 8), (k % 8) == 7, k == 15};
            act = {beat_q[k].data, beat_q[k].neuron, beat_q[k].index, beat_q[k].li, beat_q[k].l};
            total++; if (act !== exp) $display("FAIL restart_beat%0d got %h want %h", k, act, exp); else passed++;
        end
    endtask

    task automatic test_reset_mid;
        logic [23:0] act, exp;
        wmode = 0;
        run_layer(2'd0, 4'd3, 10'd3, 0, 40, -1, 5);
        total++; if (rst_snap !== '0) $display("FAIL midreset_outputs got %h want 0", rst_snap); else passed++;
        total++; if (beat_q.size() !== 5) $display("FAIL midreset_beats got %0d want 5", beat_q.size()); else passed++;
        total++; if (post_beats !== 0) $display("FAIL midreset_post_beats got %0d want 0", post_beats); else passed++;
        total++; if (post_dones !== 0) $display("FAIL midreset_post_done got %0d want 0", post_dones); else passed++;
        run_layer(2'd0, 4'd3, 10'd3, 0, 60, -1, 0);
        total++; if (beat_q.size() !== 16) $display("FAIL rerun_beats got %0d want 16", beat_q.size()); else passed++;
        total++; if (done_cyc !== 19) $display("FAIL rerun_done_cycle got %0d want 19", done_cyc); else passed++;
        total++; if (done_cnt !== 1) $display("FAIL rerun_done_count got %0d want 1", done_cnt); else passed++;
        for (int k = 0; k < beat_q.size(); k++) begin
            exp = {2'b00, 2'(k / 4), 4'(k % 4), 4'(k / 4), 10'(k % 4), (k % 4) == 3, k == 15};
            act = {beat_q[k].data, beat_q[k].neuron, beat_q[k].index, beat_q[k].li, beat_q[k].l};
            total++; if (act !== exp) $display("FAIL rerun_beat%0d got %h want %h", k, act, exp); else passed++;
        end
    endtask

    task automatic test_single;
        logic [23:0] act;
        wmode = 1;
        run_layer(2'd0, 4'd0, 10'd0, 0, 30, -1, 0);
        total++; if (beat_q.size() !== 1) $display("FAIL single_beats got %0d want 1", beat_q.size()); else passed++;
        total++; if (addr_q.size() !== 1) $display("FAIL single_addr_count got %0d want 1", addr_q.size()); else passed++;
        if (addr_q.size() > 0) begin
            total++; if (addr_q[0] !== 16'h0000) $display("FAIL single_addr got %h want 0000", addr_q[0]); else passed++;
        end
        if (beat_q.size() > 0) begin
            act = {beat_q[0].data, beat_q[0].neuron, beat_q[0].index, beat_q[0].li, beat_q[0].l};
            total++; if (act !== {8'd2, 4'd0, 10'd0, 1'b1, 1'b1}) $display("FAIL single_beat got %h want %h", act, {8'd2, 4'd0, 10'd0, 1'b1, 1'b1}); else passed++;
            total++; if (beat_q[0].cyc !== 3) $display("FAIL single_beat_cycle got %0d want 3", beat_q[0].cyc); else passed++;
        end
        total++; if (done_cyc !== 4) $display("FAIL single_done_cycle got %0d want 4", done_cyc); else passed++;
        total++; if (done_cnt !== 1) $display("FAIL single_done_count got %0d want 1", done_cnt); else passed++;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; layer = 2'd0; num_neurons_m1 = '0; num_inputs_m1 = '0;
        w_ready = 1'b1; wmode = 1;
        test_reset();
        test_full_layer();
        test_stall();
        test_toggle();
        test_restart_ignored();
        test_reset_mid();
        test_single();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
